// File: rtl/cam_fifo_ctrl.sv
// One-shot camera frame capture: gates camera pixels into the pixel FIFO for a single frame
// and drains the FIFO to a valid/ready consumer, tracking FIFO occupancy internally.
module cam_fifo_ctrl #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int DEPTH   = 1024,
    parameter int OCC_W   = 11
) (
    input  logic       Pclk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [9:0] cam_data,
    output logic       fifo_wr,
    output logic [9:0] fifo_din,
    output logic       fifo_rd,
    input  logic [9:0] fifo_dout,
    output logic       cons_valid,
    output logic [9:0] cons_data,
    input  logic       cons_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       overflow,
    output logic       line_err
);

    typedef enum logic [2:0] {IDLE, ARM, CAPT, DRAIN, DONE} state_t;

    localparam logic [OCC_W-1:0] DEPTH_C   = OCC_W'(DEPTH);
    localparam logic [15:0]      H_PIX_C   = 16'(H_PIX);
    localparam logic [15:0]      V_LINES_C = 16'(V_LINES);

    state_t           state_q, state_d;
    logic             vsyncPrev_q, hrefPrev_q;
    logic [15:0]      pixCnt_q, pixCnt_d;
    logic [15:0]      lineCnt_q, lineCnt_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             fifoWr_q, fifoWr_d;
    logic [9:0]       fifoDin_q, fifoDin_d;
    logic             consValid_q, consValid_d;
    logic             overflow_q, overflow_d;
    logic             lineErr_q, lineErr_d;
    logic             rdEn, pixelIn, vsyncFall, vsyncRise, hrefFall;

    always_ff @(posedge Pclk) begin
        if (rst) begin
            state_q     <= IDLE;
            vsyncPrev_q <= 1'b0;
            hrefPrev_q  <= 1'b0;
            pixCnt_q    <= '0;
            lineCnt_q   <= '0;
            occ_q       <= '0;
            fifoWr_q    <= 1'b0;
            fifoDin_q   <= '0;
            consValid_q <= 1'b0;
            overflow_q  <= 1'b0;
            lineErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsyncPrev_q <= cam_vsync;
            hrefPrev_q  <= cam_href;
            pixCnt_q    <= pixCnt_d;
            lineCnt_q   <= lineCnt_d;
            occ_q       <= occ_d;
            fifoWr_q    <= fifoWr_d;
            fifoDin_q   <= fifoDin_d;
            consValid_q <= consValid_d;
            overflow_q  <= overflow_d;
            lineErr_q   <= lineErr_d;
        end
    end

    // The write decision uses the occupancy the FIFO will have when the registered strobe lands,
    // so a read issued this cycle frees room for next cycle's write.
    always_comb begin
        rdEn        = (occ_q != '0) && (!consValid_q || cons_ready);
        vsyncFall   = vsyncPrev_q && !cam_vsync;
        vsyncRise   = !vsyncPrev_q && cam_vsync;
        hrefFall    = hrefPrev_q && !cam_href;
        occ_d       = occ_q + OCC_W'(fifoWr_q) - OCC_W'(rdEn);
        pixelIn     = (state_q == CAPT) && cam_href && !abort && (lineCnt_q != V_LINES_C);
        fifoWr_d    = pixelIn && (occ_d < DEPTH_C);
        fifoDin_d   = fifoWr_d ? cam_data : fifoDin_q;
        consValid_d = rdEn ? 1'b1 : (cons_ready ? 1'b0 : consValid_q);

        state_d    = state_q;
        pixCnt_d   = pixCnt_q;
        lineCnt_d  = lineCnt_q;
        overflow_d = overflow_q || (pixelIn && !fifoWr_d);
        lineErr_d  = lineErr_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARM;
                    pixCnt_d   = '0;
                    lineCnt_d  = '0;
                    overflow_d = 1'b0;
                    lineErr_d  = 1'b0;
                end
            end
            ARM: begin
                if (vsyncFall) state_d = CAPT;
            end
            CAPT: begin
                if (hrefFall) begin
                    if (pixCnt_q != H_PIX_C) lineErr_d = 1'b1;
                    if (lineCnt_q != 16'hFFFF) lineCnt_d = lineCnt_q + 16'd1;
                    pixCnt_d = '0;
                end else if (cam_href && pixCnt_q != 16'hFFFF) begin
                    pixCnt_d = pixCnt_q + 16'd1;
                end
                if (lineCnt_q == V_LINES_C || vsyncRise) state_d = DRAIN;
            end
            DRAIN: begin
                // An in-flight write strobe must land before the FIFO can be called empty.
                if (occ_q == '0 && !consValid_q && !fifoWr_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) state_d = IDLE;
    end

    assign fifo_wr    = fifoWr_q;
    assign fifo_din   = fifoDin_q;
    assign fifo_rd    = rdEn;
    assign cons_valid = consValid_q;
    assign cons_data  = fifo_dout;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign overflow   = overflow_q;
    assign line_err   = lineErr_q;

endmodule

// File: tb/tb_cam_fifo_ctrl.sv
// Scoreboard bench for cam_fifo_ctrl: a behavioural FIFO sits between the controller's strobes,
// stimulus queues the pixels that should reach the consumer and a negedge monitor checks them.
module tb_cam_fifo_ctrl;

    localparam int H_PIX   = 4;
    localparam int V_LINES = 4;
    localparam int DEPTH   = 8;
    localparam int OCC_W   = 4;

    logic       Pclk = 1'b0;
    logic       rst, start, abort, cam_vsync, cam_href, cons_ready;
    logic [9:0] cam_data;
    logic       fifo_wr, fifo_rd, cons_valid, busy, frame_done, overflow, line_err;
    logic [9:0] fifo_din, fifo_dout, cons_data;

    int checks = 0;
    int errors = 0;
    int doneCnt = 0;
    int wrCnt = 0;
    int readyMode = 0;
    bit inGap = 1'b0;
    int acceptCnt = 0;
    int capLimit = 1000;
    logic [9:0] expQ[$];
    int lineLens[$];

    logic [9:0] fifoMem[DEPTH];
    int fifoCount = 0;
    int fifoWp = 0;
    int fifoRp = 0;

    cam_fifo_ctrl #(.H_PIX(H_PIX), .V_LINES(V_LINES), .DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
        .Pclk(Pclk), .rst(rst), .start(start), .abort(abort),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
        .cons_valid(cons_valid), .cons_data(cons_data), .cons_ready(cons_ready),
        .busy(busy), .frame_done(frame_done), .overflow(overflow), .line_err(line_err)
    );

    always #5 Pclk = ~Pclk;

    // Behavioural pixel FIFO sharing the controller's reset; dout holds between reads.
    always @(posedge Pclk) begin
        if (rst) begin
            fifoCount = 0;
            fifoWp = 0;
            fifoRp = 0;
            fifo_dout <= '0;
        end else begin
            int c;
            c = fifoCount;
            if (fifo_rd && c > 0) begin
                fifo_dout <= fifoMem[fifoRp];
                fifoRp = (fifoRp + 1) % DEPTH;
                fifoCount = fifoCount - 1;
            end
            if (fifo_wr && c < DEPTH) begin
                fifoMem[fifoWp] = fifo_din;
                fifoWp = (fifoWp + 1) % DEPTH;
                fifoCount = fifoCount + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every consumer handshake and watches strobe legality.
    initial begin
        bit prevValid, prevReady;
        logic [9:0] prevData;
        prevValid = 1'b0;
        prevReady = 1'b0;
        prevData = '0;
        forever begin
            @(negedge Pclk);
            if (rst) begin
                prevValid = 1'b0;
            end else begin
                if (prevValid && !prevReady) begin
                    checkOutput("hold_valid", int'(cons_valid), 1);
                    checkOutput("hold_data", int'(cons_data), int'(prevData));
                end
                if (cons_valid && cons_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_pixel actual=%0d expected=none at %0t",
                                 cons_data, $time);
                    end else begin
                        logic [9:0] e;
                        e = expQ.pop_front();
                        checkOutput("pixel", int'(cons_data), int'(e));
                    end
                end
                if (fifo_rd) checkOutput("rd_nonempty", int'(fifoCount > 0), 1);
                if (fifo_wr && !(fifo_rd && fifoCount > 0))
                    checkOutput("wr_room", int'(fifoCount < DEPTH), 1);
                if (fifo_wr) wrCnt++;
                if (frame_done) doneCnt++;
                prevValid = cons_valid;
                prevReady = cons_ready;
                prevData = cons_data;
            end
        end
    end

    task automatic tick();
        @(posedge Pclk);
        #1;
        case (readyMode)
            0: cons_ready = 1'b1;
            1: cons_ready = inGap ? 1'b1 : 1'($urandom_range(0, 1));
            2: cons_ready = inGap ? 1'b1 : ~cons_ready;
            default: cons_ready = 1'b0;
        endcase
    endtask

    // One HREF line of random pixels followed by a long gap in which the consumer drains.
    task automatic applyStimulus(input int len, input bit capturing);
        inGap = 1'b0;
        for (int i = 0; i < len; i++) begin
            cam_href = 1'b1;
            cam_data = 10'($urandom_range(0, 1023));
            if (capturing && acceptCnt < capLimit) begin
                expQ.push_back(cam_data);
                acceptCnt++;
            end
            tick();
        end
        cam_href = 1'b0;
        inGap = 1'b1;
        repeat (12) tick();
    endtask

    task automatic runFrame(input bit doStart, input int drainMode);
        acceptCnt = 0;
        cam_vsync = 1'b1;
        repeat (3) tick();
        if (doStart) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
        foreach (lineLens[i]) applyStimulus(lineLens[i], 1'b1);
        readyMode = drainMode;
        cam_vsync = 1'b1;
        tick();
    endtask

    task automatic waitDone(input string name, input int startCnt);
        int n;
        n = 0;
        while (doneCnt == startCnt && n < 400) begin
            tick();
            n++;
        end
        repeat (3) tick();
        checkOutput({name, "_done_once"}, doneCnt - startCnt, 1);
        checkOutput({name, "_drained"}, expQ.size(), 0);
        checkOutput({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        int d0, w0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0;
        cam_data = '0; cons_ready = 1'b1;
        tick(); tick();
        checkOutput("rst_fifo_wr", int'(fifo_wr), 0);
        checkOutput("rst_fifo_rd", int'(fifo_rd), 0);
        checkOutput("rst_fifo_din", int'(fifo_din), 0);
        checkOutput("rst_cons_valid", int'(cons_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_frame_done", int'(frame_done), 0);
        checkOutput("rst_flags", int'({overflow, line_err}), 0);
        rst = 1'b0;
        tick();

        // Full 4x4 frame, consumer always ready.
        lineLens = '{4, 4, 4, 4};
        readyMode = 0; capLimit = 1000; d0 = doneCnt;
        runFrame(1'b1, 0);
        waitDone("basic", d0);
        checkOutput("basic_line_err", int'(line_err), 0);
        checkOutput("basic_overflow", int'(overflow), 0);

        // Short second line flags line_err but the rest of the frame is still captured.
        lineLens = '{4, 3, 4, 4};
        d0 = doneCnt;
        runFrame(1'b1, 0);
        waitDone("short", d0);
        checkOutput("short_line_err", int'(line_err), 1);
        checkOutput("short_overflow", int'(overflow), 0);

        // Consumer stalled for the whole capture: one pixel sits in the output stage and DEPTH
        // fill the FIFO, so exactly the first DEPTH+1 pixels survive.
        lineLens = '{4, 4, 4, 4};
        readyMode = 3; capLimit = DEPTH + 1; d0 = doneCnt;
        runFrame(1'b1, 0);
        waitDone("ovf", d0);
        checkOutput("ovf_overflow", int'(overflow), 1);
        checkOutput("ovf_line_err_cleared", int'(line_err), 0);
        capLimit = 1000;

        // Start while vsync is already low: nothing is written until the next vsync fall.
        readyMode = 0;
        cam_vsync = 1'b0;
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        checkOutput("arm_busy", int'(busy), 1);
        checkOutput("arm_overflow_cleared", int'(overflow), 0);
        w0 = wrCnt;
        applyStimulus(4, 1'b0);
        checkOutput("arm_no_write", wrCnt - w0, 0);
        d0 = doneCnt;
        runFrame(1'b0, 0);
        waitDone("armwait", d0);
        checkOutput("armwait_line_err", int'(line_err), 0);

        // Alternating ready during lines, then two frames of random ready.
        readyMode = 2; d0 = doneCnt;
        runFrame(1'b1, 0);
        waitDone("toggle", d0);
        for (int f = 0; f < 2; f++) begin
            readyMode = 1; d0 = doneCnt;
            runFrame(1'b1, 0);
            waitDone("random", d0);
            checkOutput("random_overflow", int'(overflow), 0);
        end

        // Abort mid-line: earlier pixels still drain, the abort-cycle pixel is dropped.
        readyMode = 0; d0 = doneCnt; acceptCnt = 0;
        cam_vsync = 1'b1; repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        cam_vsync = 1'b0; repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            cam_href = 1'b1;
            cam_data = 10'($urandom_range(0, 1023));
            expQ.push_back(cam_data);
            tick();
        end
        cam_data = 10'($urandom_range(0, 1023));
        abort = 1'b1;
        tick();
        abort = 1'b0; cam_href = 1'b0;
        checkOutput("abort_idle", int'(busy), 0);
        checkOutput("abort_no_wr", int'(fifo_wr), 0);
        repeat (15) tick();
        checkOutput("abort_drained", expQ.size(), 0);
        checkOutput("abort_no_done", doneCnt - d0, 0);

        // Reset in the middle of a captured line with the consumer stalled.
        readyMode = 3;
        cam_vsync = 1'b1; repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        cam_vsync = 1'b0; repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            cam_href = 1'b1;
            cam_data = 10'($urandom_range(0, 1023));
            tick();
        end
        cam_href = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_fifo_wr", int'(fifo_wr), 0);
        checkOutput("mid_rst_fifo_rd", int'(fifo_rd), 0);
        checkOutput("mid_rst_fifo_din", int'(fifo_din), 0);
        checkOutput("mid_rst_cons_valid", int'(cons_valid), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_flags", int'({overflow, line_err, frame_done}), 0);
        readyMode = 0;
        repeat (20) tick();
        checkOutput("post_rst_empty", int'(cons_valid | fifo_rd), 0);
        checkOutput("post_rst_queue", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
